// File: rtl/tlul_socket_m1_rr.sv
// M:1 TL-UL socket: merges M host ports onto one device port.
// A channel is arbitrated round-robin. A granted host stays locked until its
// beat is accepted. The host index is tagged into the low a_source bits so that
// D responses route back to the issuing host. Per-host outstanding counters
// limit each host to MaxOutPerHost requests in flight.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tl_h_i[M]     : host requests (A channel + d_ready)
//   tl_h_o[M]     : host responses (D channel + a_ready)
//   tl_d_o        : merged device request
//   tl_d_i        : device response

package tlul_socket_m1_rr_pkg;
   localparam int unsigned TL_AW  = 32;
   localparam int unsigned TL_DW  = 32;
   localparam int unsigned TL_AIW = 8;
   localparam int unsigned TL_DIW = 1;
   localparam int unsigned TL_SZW = 2;
   localparam int unsigned TL_DBW = TL_DW / 8;

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
      logic              d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic              d_valid;
      logic [2:0]        d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic [TL_DIW-1:0] d_sink;
      logic [TL_DW-1:0]  d_data;
      logic              d_error;
      logic              a_ready;
   } tl_d2h_t;
endpackage

module tlul_socket_m1_rr
   import tlul_socket_m1_rr_pkg::*;
#(
   parameter int unsigned M             = 4,
   parameter int unsigned MaxOutPerHost = 4
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  tl_h2d_t tl_h_i [M],
   output tl_d2h_t tl_h_o [M],
   output tl_h2d_t tl_d_o,
   input  tl_d2h_t tl_d_i
);

   localparam int unsigned     StIdW  = $clog2(M);
   localparam int unsigned     CntW   = $clog2(MaxOutPerHost + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutPerHost);

   logic [StIdW-1:0] last_q, last_d;
   logic             lock_q, lock_d;
   logic [StIdW-1:0] lock_idx_q, lock_idx_d;
   logic [CntW-1:0]  cnt_q [M];
   logic [CntW-1:0]  cnt_d [M];

   logic [M-1:0]     elig;
   logic [StIdW-1:0] grant;
   logic             granted;
   logic             gnt_vld;
   logic             acc_a;
   logic             acc_d;
   logic [StIdW-1:0] ridx;
   logic             ridx_ok;
   logic             d_ready_sel;
   logic             d_ready_c;
   logic [M-1:0]     inc;
   logic [M-1:0]     dec;
   int unsigned      idx;

   // Round-robin search starting after last; a locked host overrides the search.
   always_comb begin : arb
      grant   = lock_idx_q;
      granted = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < M; i++) begin
         elig[i] = tl_h_i[i].a_valid && (cnt_q[i] < CntMax);
      end
      if (lock_q) begin
         granted = tl_h_i[lock_idx_q].a_valid;
      end else begin
         for (int unsigned k = 1; k <= M; k++) begin
            idx = (32'(last_q) + k) % M;
            if (!granted && elig[StIdW'(idx)]) begin
               grant   = StIdW'(idx);
               granted = 1'b1;
            end
         end
      end
      gnt_vld = granted & rst_ni;
      acc_a   = gnt_vld & tl_d_i.a_ready;
   end

   // Response index; indices beyond M-1 are strays that get sunk.
   always_comb begin : rsel
      ridx        = tl_d_i.d_source[StIdW-1:0];
      ridx_ok     = (32'(ridx) < M);
      d_ready_sel = 1'b1;
      for (int unsigned i = 0; i < M; i++) begin
         if (ridx == StIdW'(i)) begin
            d_ready_sel = tl_h_i[i].d_ready;
         end
      end
      d_ready_c = rst_ni & d_ready_sel;
      acc_d     = rst_ni & tl_d_i.d_valid & d_ready_c & ridx_ok;
   end

   // Device request: granted host's A fields with host index in a_source LSBs.
   always_comb begin : fwd
      tl_d_o          = tl_h_i[grant];
      tl_d_o.a_valid  = gnt_vld;
      tl_d_o.a_source = {tl_h_i[grant].a_source[TL_AIW-StIdW-1:0], grant};
      tl_d_o.d_ready  = d_ready_c;
   end

   // Host responses: D fields broadcast, d_valid/a_ready steered per host.
   always_comb begin : rsp
      for (int unsigned i = 0; i < M; i++) begin
         tl_h_o[i]          = tl_d_i;
         tl_h_o[i].d_valid  = rst_ni & tl_d_i.d_valid & (ridx == StIdW'(i));
         tl_h_o[i].d_source = tl_d_i.d_source >> StIdW;
         tl_h_o[i].a_ready  = gnt_vld & (grant == StIdW'(i)) & tl_d_i.a_ready;
      end
   end

   // Next-state: pointer, lock and saturating outstanding counters.
   always_comb begin : nxt
      last_d     = acc_a ? grant : last_q;
      lock_d     = gnt_vld & ~tl_d_i.a_ready;
      lock_idx_d = lock_d ? grant : lock_idx_q;
      for (int unsigned i = 0; i < M; i++) begin
         inc[i]   = acc_a & (grant == StIdW'(i));
         dec[i]   = acc_d & (ridx == StIdW'(i));
         cnt_d[i] = cnt_q[i];
         if (inc[i] && !dec[i] && (cnt_q[i] != CntMax)) begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end else if (dec[i] && !inc[i] && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin : regs
      if (!rst_ni) begin
         last_q     <= StIdW'(M - 1);
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         for (int unsigned i = 0; i < M; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         last_q     <= last_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         for (int unsigned i = 0; i < M; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Protocol checks: host tag bits free, counters never wrap.
   for (genvar gi = 0; gi < M; gi++) begin : g_chk
      a_src_hi_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
         tl_h_i[gi].a_valid |-> (tl_h_i[gi].a_source[TL_AIW-1 -: StIdW] == '0));
      a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (dec[gi] && !inc[gi]) |-> (cnt_q[gi] != '0));
      a_cnt_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (inc[gi] && !dec[gi]) |-> (cnt_q[gi] != CntMax));
   end

endmodule

// File: tb/tb_tlul_socket_m1_rr.sv
// Bench for tlul_socket_m1_rr: directed scenarios with literal expectations,
// then randomized host/device traffic checked every cycle against a
// behavioural model (pointer, lock, outstanding counts as plain integers).
module tb_tlul_socket_m1_rr;
   import tlul_socket_m1_rr_pkg::*;

   localparam int NM   = 4;
   localparam int MAXO = 2;

   logic    clk = 1'b0;
   logic    rst_n;
   tl_h2d_t h_in  [NM];
   tl_d2h_t h_out [NM];
   tl_h2d_t d_out;
   tl_d2h_t d_in;
   tl_h2d_t h2_in  [5];
   tl_d2h_t h2_out [5];
   tl_h2d_t d2_out;
   tl_d2h_t d2_in;

   tlul_socket_m1_rr #(.M(NM), .MaxOutPerHost(MAXO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_in), .tl_h_o(h_out),
      .tl_d_o(d_out), .tl_d_i(d_in));

   tlul_socket_m1_rr #(.M(5), .MaxOutPerHost(1)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h2_in), .tl_h_o(h2_out),
      .tl_d_o(d2_out), .tl_d_i(d2_in));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state
   int m_last, m_lock, m_lock_idx;
   int m_cnt [NM];
   bit exp_acc, exp_dacc;
   int exp_grant;

   always @(negedge clk) begin
      int g;
      bit gv;
      int ridx;
      bit dr;
      bit ev;
      #1;
      if (!rst_n) begin
         m_last = NM - 1; m_lock = 0; m_lock_idx = 0;
         for (int i = 0; i < NM; i++) m_cnt[i] = 0;
         exp_acc = 0; exp_dacc = 0; exp_grant = 0;
         chk("rst_a_valid", d_out.a_valid, 0);
         chk("rst_d_ready", d_out.d_ready, 0);
         for (int i = 0; i < NM; i++) begin
            chk($sformatf("rst_h%0d_a_ready", i), h_out[i].a_ready, 0);
            chk($sformatf("rst_h%0d_d_valid", i), h_out[i].d_valid, 0);
         end
      end else begin
         gv = 0; g = 0;
         if (m_lock != 0) begin
            g  = m_lock_idx;
            gv = h_in[g].a_valid;
         end else begin
            for (int k = 1; k <= NM; k++) begin
               int h;
               h = (m_last + k) % NM;
               if (!gv && h_in[h].a_valid && m_cnt[h] < MAXO) begin
                  g = h; gv = 1;
               end
            end
         end
         chk("a_valid", d_out.a_valid, gv);
         if (gv) begin
            chk("a_source", d_out.a_source, (int'(h_in[g].a_source) % 64) * 4 + g);
            chk("a_address", d_out.a_address, h_in[g].a_address);
            chk("a_data", d_out.a_data, h_in[g].a_data);
            chk("a_mask", d_out.a_mask, h_in[g].a_mask);
            chk("a_opcode", d_out.a_opcode, h_in[g].a_opcode);
            chk("a_size", d_out.a_size, h_in[g].a_size);
         end
         for (int i = 0; i < NM; i++)
            chk($sformatf("h%0d_a_ready", i), h_out[i].a_ready, gv && g == i && d_in.a_ready);
         ridx = int'(d_in.d_source) % NM;
         dr   = h_in[ridx].d_ready;
         chk("d_ready", d_out.d_ready, dr);
         for (int i = 0; i < NM; i++) begin
            ev = d_in.d_valid && ridx == i;
            chk($sformatf("h%0d_d_valid", i), h_out[i].d_valid, ev);
            if (ev) begin
               chk("d_source", h_out[i].d_source, int'(d_in.d_source) / NM);
               chk("d_data", h_out[i].d_data, d_in.d_data);
            end
         end
         exp_acc   = gv && d_in.a_ready;
         exp_grant = g;
         exp_dacc  = d_in.d_valid && dr;
         if (exp_acc) begin
            m_last = g; m_lock = 0;
            if (m_cnt[g] < MAXO) m_cnt[g]++;
         end else begin
            m_lock = gv ? 1 : 0;
            if (gv) m_lock_idx = g;
         end
         if (exp_dacc && m_cnt[ridx] > 0) m_cnt[ridx]--;
      end
   end

   logic [7:0] dq [$];
   int d_idx;

   task automatic drv();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk); #2;
   endtask

   task automatic idle();
      for (int i = 0; i < NM; i++) h_in[i] = '0;
      for (int i = 0; i < 5; i++) h2_in[i] = '0;
      d_in = '0;
      d2_in = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      dq.delete();
      drv();
      rst_n = 1'b1;
   endtask

   task automatic set_host(input int i, input logic [7:0] src, input logic [31:0] addr);
      h_in[i].a_valid   = 1'b1;
      h_in[i].a_source  = src;
      h_in[i].a_address = addr;
      h_in[i].a_data    = ~addr;
      h_in[i].a_mask    = 4'hF;
   endtask

   // One random stimulus step, issued just after a clock edge.
   task automatic gen();
      if (d_in.d_valid && exp_dacc) begin
         dq.delete(d_idx);
         d_in.d_valid = 1'b0;
      end
      for (int i = 0; i < NM; i++) begin
         if (h_in[i].a_valid && exp_acc && exp_grant == i) begin
            dq.push_back(8'((int'(h_in[i].a_source) % 64) * 4 + i));
            h_in[i].a_valid = 1'b0;
         end
         if (!h_in[i].a_valid && ($urandom % 3) == 0) begin
            h_in[i].a_valid   = 1'b1;
            h_in[i].a_opcode  = 3'($urandom);
            h_in[i].a_size    = 2'($urandom);
            h_in[i].a_source  = {2'b00, 6'($urandom)};
            h_in[i].a_address = $urandom;
            h_in[i].a_mask    = 4'($urandom);
            h_in[i].a_data    = $urandom;
         end
         h_in[i].d_ready = ($urandom % 4) != 0;
      end
      if (!d_in.d_valid && dq.size() > 0 && ($urandom % 2) == 1) begin
         d_idx            = int'($urandom % dq.size());
         d_in.d_valid     = 1'b1;
         d_in.d_source    = dq[d_idx];
         d_in.d_data      = $urandom;
         d_in.d_opcode    = 3'($urandom);
      end
      d_in.a_ready = ($urandom % 4) != 0;
   endtask

   int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      rst_n = 1'b0;
      idle();
      // Reset gating with live inputs
      set_host(0, 8'h00, 32'h0);
      h_in[0].d_ready = 1'b1;
      d_in.a_ready = 1'b1;
      d_in.d_valid = 1'b1;
      smp();
      chk("reset_dev_a_valid", d_out.a_valid, 0);
      chk("reset_h0_d_valid", h_out[0].d_valid, 0);
      drv();
      idle();
      rst_n = 1'b1;

      // Round-robin with all hosts requesting
      for (int i = 0; i < NM; i++) set_host(i, 8'h00, 32'(i));
      d_in.a_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         smp();
         chk($sformatf("rr_grant%0d", c), d_out.a_source, rr_exp[c]);
         drv();
      end
      do_reset();

      // Single host, tag and untag
      set_host(2, 8'h05, 32'h1000_0020);
      d_in.a_ready = 1'b1;
      smp();
      chk("single_a_source", d_out.a_source, 8'h16);
      chk("single_h2_a_ready", h_out[2].a_ready, 1);
      chk("single_a_address", d_out.a_address, 32'h1000_0020);
      drv();
      h_in[2].a_valid = 1'b0;
      h_in[2].d_ready = 1'b1;
      d_in.d_valid = 1'b1; d_in.d_source = 8'h16; d_in.d_data = 32'h1234_5678;
      smp();
      chk("single_h2_d_valid", h_out[2].d_valid, 1);
      chk("single_h2_d_source", h_out[2].d_source, 8'h05);
      chk("single_h1_d_valid", h_out[1].d_valid, 0);
      chk("single_d_ready", d_out.d_ready, 1);
      drv();
      d_in.d_valid = 1'b0;

      // Lock: host 1 stalled three cycles, host 0 arrives meanwhile
      d_in.a_ready = 1'b0;
      set_host(1, 8'h01, 32'h0000_00A1);
      smp();
      chk("lock_c1_a_source", d_out.a_source, 8'h05);
      drv();
      set_host(0, 8'h00, 32'h0000_00A0);
      smp();
      chk("lock_c2_a_address", d_out.a_address, 32'h0000_00A1);
      chk("lock_c2_h0_a_ready", h_out[0].a_ready, 0);
      drv();
      smp();
      chk("lock_c3_a_address", d_out.a_address, 32'h0000_00A1);
      drv();
      d_in.a_ready = 1'b1;
      smp();
      chk("lock_c4_h1_a_ready", h_out[1].a_ready, 1);
      drv();
      h_in[1].a_valid = 1'b0;
      smp();
      chk("lock_c5_a_address", d_out.a_address, 32'h0000_00A0);
      chk("lock_c5_h0_a_ready", h_out[0].a_ready, 1);
      drv();
      h_in[0].a_valid = 1'b0;

      // Throttle host 3 at two outstanding
      set_host(3, 8'h00, 32'h0000_00B0);
      smp();
      chk("thr_r1_a_ready", h_out[3].a_ready, 1);
      drv();
      h_in[3].a_address = 32'h0000_00B1;
      smp();
      chk("thr_r2_a_ready", h_out[3].a_ready, 1);
      drv();
      h_in[3].a_address = 32'h0000_00B2;
      smp();
      chk("thr_r3_stall", h_out[3].a_ready, 0);
      chk("thr_r3_dev_a_valid", d_out.a_valid, 0);
      drv();
      d_in.d_valid = 1'b1; d_in.d_source = 8'h03; h_in[3].d_ready = 1'b1;
      smp();
      chk("thr_rsp_d_valid", h_out[3].d_valid, 1);
      chk("thr_rsp_still_stall", h_out[3].a_ready, 0);
      drv();
      d_in.d_valid = 1'b0;
      smp();
      chk("thr_r3_accept", h_out[3].a_ready, 1);
      drv();
      h_in[3].a_valid = 1'b0;

      // Simultaneous accept and response on host 0 (one outstanding)
      set_host(0, 8'h00, 32'h0000_00C0);
      h_in[0].d_ready = 1'b1;
      d_in.d_valid = 1'b1; d_in.d_source = 8'h00;
      smp();
      chk("sim_a_ready", h_out[0].a_ready, 1);
      chk("sim_d_valid", h_out[0].d_valid, 1);
      drv();
      d_in.d_valid = 1'b0;
      h_in[0].a_address = 32'h0000_00C1;
      smp();
      chk("sim_next_accept", h_out[0].a_ready, 1);
      drv();
      h_in[0].a_address = 32'h0000_00C2;
      smp();
      chk("sim_then_stall", h_out[0].a_ready, 0);
      drv();
      do_reset();

      // Five-host instance: tag width 3, stray response, single outstanding
      h2_in[4].a_valid = 1'b1; h2_in[4].a_source = 8'h05; h2_in[4].a_address = 32'hD4;
      d2_in.a_ready = 1'b1;
      smp();
      chk("m5_a_source", d2_out.a_source, 8'h2C);
      chk("m5_h4_a_ready", h2_out[4].a_ready, 1);
      drv();
      d2_in.d_valid = 1'b1; d2_in.d_source = 8'h07;
      smp();
      chk("stray_d_ready", d2_out.d_ready, 1);
      for (int i = 0; i < 5; i++)
         chk($sformatf("stray_h%0d_d_valid", i), h2_out[i].d_valid, 0);
      chk("m5_h4_limit_stall", h2_out[4].a_ready, 0);
      drv();
      d2_in.d_source = 8'h2C; h2_in[4].d_ready = 1'b1;
      smp();
      chk("m5_h4_d_valid", h2_out[4].d_valid, 1);
      chk("m5_h4_d_source", h2_out[4].d_source, 8'h05);
      chk("m5_h4_stall_on_rsp", h2_out[4].a_ready, 0);
      drv();
      d2_in.d_valid = 1'b0;
      smp();
      chk("m5_h4_accept_after_rsp", h2_out[4].a_ready, 1);
      drv();
      do_reset();

      // Random traffic with a reset part-way through
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            do_reset();
         end else begin
            gen();
            drv();
         end
      end
      smp();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
